// File: rtl/pwm_multi.sv
// ---------------------------------------------------------------------------
// pwm_multi -- multi-channel PWM generator
//
// One prescaled period counter is shared by CHANNELS compare outputs. Each
// channel has a shadow duty register that firmware may write at any time. The
// shadow value is copied into the active register only at a period boundary,
// which is the tick on which the counter becomes 0. This avoids glitches.
//
// Build option:
//   PWM_CENTER_ALIGN_EN  defined   -> triangle counter 0..2^N-1..1, boundary
//                                     at the valley
//                        undefined -> sawtooth counter 0..2^N-1, no direction
//                                     register
//
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_enable            run the prescaler and counter; when low, o_pwm is 0
//   i_prescale          tick every i_prescale+1 clocks
//   i_wr_valid/chan/duty  duty write (always accepted). Values >= 2^N are
//                       saturated. Channels >= CHANNELS are ignored.
//   o_pwm               registered compare outputs, one per channel
//   o_counter           period counter
//   o_period_start      one-clock pulse when the counter has just loaded 0
// ---------------------------------------------------------------------------

// Per-channel shadow/active duty pair and registered compare.
module pwm_multi_chan #(
    parameter int PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_wr_hit,
    input  logic [PWM_BITS:0]   i_wr_duty,
    input  logic                i_boundary,
    input  logic [PWM_BITS-1:0] i_cnt_nxt,
    output logic                o_pwm
);
    logic [PWM_BITS:0] r_shadow;
    logic [PWM_BITS:0] r_active;
    logic [PWM_BITS:0] w_act_nxt;
    logic              r_pwm;

    // A write that lands on the boundary goes straight into active.
    always_comb begin
        w_act_nxt = r_active;
        if (i_boundary)
            w_act_nxt = i_wr_hit ? i_wr_duty : r_shadow;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shadow <= '0;
            r_active <= '0;
            r_pwm    <= 1'b0;
        end else begin
            if (i_wr_hit)
                r_shadow <= i_wr_duty;
            r_active <= w_act_nxt;
            // The compare uses next-state values, so o_pwm stays coherent with
            // o_counter.
            r_pwm    <= i_enable && ({1'b0, i_cnt_nxt} < w_act_nxt);
        end
    end

    assign o_pwm = r_pwm;
endmodule

module pwm_multi #(
    parameter int CHANNELS      = 4,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE_BITS = 8,
    parameter int CHAN_BITS     = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic [PRESCALE_BITS-1:0] i_prescale,
    input  logic                     i_wr_valid,
    input  logic [CHAN_BITS-1:0]     i_wr_chan,
    input  logic [PWM_BITS:0]        i_wr_duty,
    output logic [CHANNELS-1:0]      o_pwm,
    output logic [PWM_BITS-1:0]      o_counter,
    output logic                     o_period_start
);
    localparam logic [PWM_BITS:0]  FULL   = {1'b1, {PWM_BITS{1'b0}}};
    localparam logic [CHAN_BITS:0] CH_LIM = (CHAN_BITS+1)'(CHANNELS);

    logic [PRESCALE_BITS-1:0] r_pre_cnt;
    logic [PWM_BITS-1:0]      r_cnt;
    logic [PWM_BITS-1:0]      w_cnt_nxt;
    logic                     r_pstart;
    logic                     w_tick;
    logic                     w_bnd;
    logic                     w_chan_ok;
    logic [PWM_BITS:0]        w_duty_sat;

    // The >= compare lets a lowered prescale fire at once, so the count
    // never runs past the new limit.
    assign w_tick = i_enable && (r_pre_cnt >= i_prescale);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_pre_cnt <= '0;
        else if (i_enable)
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
    end

`ifdef PWM_CENTER_ALIGN_EN
    // Triangle counter: r_dir = 1 while counting up.
    logic r_dir;
    logic w_dir_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (w_tick) begin
            if (r_dir) begin
                if (r_cnt == '1) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    w_dir_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end else if (r_cnt == '0) begin
                // The valley normally flips direction. This branch only
                // recovers an inconsistent state.
                w_cnt_nxt = PWM_BITS'(1);
                w_dir_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == PWM_BITS'(1))
                    w_dir_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_dir <= 1'b1;
        else
            r_dir <= w_dir_nxt;
    end
`else
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_tick)
            w_cnt_nxt = r_cnt + 1'b1;
    end
`endif

    assign w_bnd = w_tick && (w_cnt_nxt == '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_pstart <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_pstart <= w_bnd;
        end
    end

    // A duty with the top bit set is 2^N or more, so clamp it to full-on.
    assign w_duty_sat = i_wr_duty[PWM_BITS] ? FULL : i_wr_duty;
    assign w_chan_ok  = ({1'b0, i_wr_chan} < CH_LIM);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic w_hit;
        assign w_hit = i_wr_valid && w_chan_ok && (i_wr_chan == CHAN_BITS'(c));

        pwm_multi_chan #(.PWM_BITS(PWM_BITS)) u_chan (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_enable   (i_enable),
            .i_wr_hit   (w_hit),
            .i_wr_duty  (w_duty_sat),
            .i_boundary (w_bnd),
            .i_cnt_nxt  (w_cnt_nxt),
            .o_pwm      (o_pwm[c])
        );
    end

    assign o_counter      = r_cnt;
    assign o_period_start = r_pstart;
endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;
`ifdef PWM_CENTER_ALIGN_EN
    localparam int N = 4;
`else
    localparam int N = 8;
`endif
    localparam int CH = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic [7:0]   pre;
    logic         wr_valid;
    logic [2:0]   wr_chan;
    logic [N:0]   wr_duty;
    logic [CH-1:0] pwm;
    logic [N-1:0] cnt;
    logic         pstart;

    int n_pass = 0;
    int n_total = 0;
    int hi[CH];
    int ps_seen;

    pwm_multi #(.CHANNELS(CH), .PWM_BITS(N), .PRESCALE_BITS(8), .CHAN_BITS(3)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_enable       (en),
        .i_prescale     (pre),
        .i_wr_valid     (wr_valid),
        .i_wr_chan      (wr_chan),
        .i_wr_duty      (wr_duty),
        .o_pwm          (pwm),
        .o_counter      (cnt),
        .o_period_start (pstart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic wait_pstart(input string nm, input int lim, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!pstart && n < lim);
        if (!pstart) chk({nm, " pstart seen"}, int'(pstart), 1);
    endtask

    task automatic wait_cnt(input int v, input int lim);
        int n = 0;
        while (int'(cnt) != v && n < lim) begin
            step();
            n++;
        end
        if (int'(cnt) != v) chk("wait counter value", int'(cnt), v);
    endtask

    task automatic steps_to_change(input int lim, output int n);
        logic [N-1:0] prev = cnt;
        n = 0;
        do begin
            step();
            n++;
        end while (cnt == prev && n < lim);
    endtask

    // Sample len clocks starting at the current sample: high count per
    // channel and any period_start after the first sample.
    task automatic measure(input int len);
        for (int c = 0; c < CH; c++) hi[c] = 0;
        ps_seen = 0;
        for (int i = 0; i < len; i++) begin
            for (int c = 0; c < CH; c++) hi[c] += int'(pwm[c]);
            if (i > 0 && pstart) ps_seen++;
            step();
        end
    endtask

    task automatic wr(input int ch, input int duty);
        wr_valid = 1'b1;
        wr_chan  = 3'(ch);
        wr_duty  = (N+1)'(duty);
        step();
        wr_valid = 1'b0;
    endtask

`ifndef PWM_CENTER_ALIGN_EN
    typedef struct {
        int chan;
        int duty;
        int exp_hi;
    } vec_t;
    vec_t vecs[6];
`endif

    initial begin
        int n;
        rst = 1'b1; en = 1'b1; pre = 8'd0;
        wr_valid = 1'b0; wr_chan = '0; wr_duty = '0;
        step();
        chk("reset pwm", int'(pwm), 0);
        chk("reset counter", int'(cnt), 0);
        chk("reset pstart", int'(pstart), 0);
        rst = 1'b0;

`ifdef PWM_CENTER_ALIGN_EN
        begin
            int pw[31];
            int cn[31];
            int ps[31];
            int bad_sym, bad_cmp, extra_ps, hsum;
            wr(0, 4);
            chk("center first counter", int'(cnt), 1);
            wait_pstart("center first boundary", 100, n);
            chk("center first boundary edge", n + 1, 30);
            chk("center pwm at valley", int'(pwm[0]), 1);
            for (int i = 0; i <= 30; i++) begin
                pw[i] = int'(pwm[0]); cn[i] = int'(cnt); ps[i] = int'(pstart);
                if (i < 30) step();
            end
            hsum = 0; bad_sym = 0; bad_cmp = 0; extra_ps = 0;
            for (int i = 0; i < 30; i++) begin
                hsum += pw[i];
                if (pw[i] != int'(cn[i] < 4)) bad_cmp++;
                if (i > 0 && ps[i] != 0) extra_ps++;
            end
            for (int i = 1; i < 15; i++)
                if (pw[i] != pw[30 - i]) bad_sym++;
            chk("center high clocks", hsum, 7);
            chk("center peak value", cn[15], 15);
            chk("center after peak", cn[16], 14);
            chk("center pulse only at valley", extra_ps, 0);
            chk("center period 30", ps[30], 1);
            chk("center compare", bad_cmp, 0);
            chk("center symmetry", bad_sym, 0);
        end
`else
        vecs[0] = '{0, 64, 64};
        vecs[1] = '{1, 0, 0};
        vecs[2] = '{2, 256, 256};
        vecs[3] = '{3, 300, 256};
        vecs[4] = '{1, 255, 255};
        vecs[5] = '{0, 1, 1};

        step();
        chk("counter after first edge", int'(cnt), 1);
        wait_pstart("first boundary", 400, n);
        chk("first boundary edge", n + 1, 256);
        chk("pwm zero before writes", int'(pwm), 0);

        for (int v = 0; v < 6; v++) begin
            wr(vecs[v].chan, vecs[v].duty);
            wait_pstart($sformatf("vec%0d", v), 600, n);
            measure(256);
            chk($sformatf("vec%0d high clocks", v), hi[vecs[v].chan], vecs[v].exp_hi);
            chk($sformatf("vec%0d one pulse/256", v), ps_seen + 2 * int'(!pstart), 0);
        end

        // Out-of-range channels must leave every channel untouched.
        wr(7, 0);
        wr(4, 0);
        wait_pstart("invalid chan", 600, n);
        measure(256);
        chk("invalid wr ch0", hi[0], 1);
        chk("invalid wr ch1", hi[1], 255);
        chk("invalid wr ch2", hi[2], 256);
        chk("invalid wr ch3", hi[3], 256);

        // A write on the boundary edge takes effect in that same period.
        wait_cnt(255, 300);
        wr(3, 10);
        chk("wt pstart", int'(pstart), 1);
        chk("wt ch3 high at 0", int'(pwm[3]), 1);
        measure(256);
        chk("wt ch3 same period", hi[3], 10);
        measure(256);
        chk("wt ch3 next period", hi[3], 10);

        // Prescaler.
        pre = 8'd3;
        steps_to_change(20, n);
        chk("prescale3 step a", n, 4);
        steps_to_change(20, n);
        chk("prescale3 step b", n, 4);
        wait_pstart("prescale align", 2000, n);
        wait_pstart("prescale period", 2000, n);
        chk("prescale3 period", n, 1024);
        step();
        step();
        pre = 8'd1;
        step();
        chk("prescale drop immediate tick", int'(cnt), 1);
        step();
        chk("prescale1 hold", int'(cnt), 1);
        step();
        chk("prescale1 tick", int'(cnt), 2);
        pre = 8'd0;

        // Enable hold and resume.
        wait_cnt(100, 300);
        en = 1'b0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (cnt != N'(100) || pwm != '0 || pstart) n++;
        end
        chk("disable bad samples", n, 0);
        chk("disable counter held", int'(cnt), 100);
        chk("disable pwm", int'(pwm), 0);
        en = 1'b1;
        step();
        chk("resume counter", int'(cnt), 101);
        chk("resume pwm", int'(pwm), 6);

        // Asynchronous reset mid-period.
        step(); step(); step();
        #1 rst = 1'b1;
        #1;
        chk("async reset pwm", int'(pwm), 0);
        chk("async reset counter", int'(cnt), 0);
        chk("async reset pstart", int'(pstart), 0);
        #1 rst = 1'b0;
        step();
        chk("post reset counter", int'(cnt), 1);
        chk("post reset pwm", int'(pwm), 0);
        wait_pstart("post reset", 300, n);
        chk("post reset duty cleared", int'(pwm), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator: one shared prescaled period counter drives `CHANNELS` independent compare outputs. Each channel has a double-buffered duty register, so firmware can write at any time without glitches. It sits between the register/bus interface and the pad drivers (LEDs, motor drivers). The block generalises the single-channel counter/comparator PWM with prescaling, enable, a period-start strobe, full-on duty and optional center-aligned mode.

## Interface
Parameters:
- `CHANNELS`, 4: number of PWM outputs, ≥1.
- `PWM_BITS`, 8: counter width N; the duty range is 0..2^N.
- `PRESCALE_BITS`, 8: prescaler width.
- `CHAN_BITS`, 2: channel index width, ≥1, with 2^CHAN_BITS ≥ CHANNELS.

Ports:
- `i_clk`, in, 1: clock.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_enable`, in, 1: run counter and outputs.
- `i_prescale`, in, PRESCALE_BITS: tick every i_prescale+1 clocks.
- `i_wr_valid`, in, 1: duty write strobe. Always accepted; there is no ready signal.
- `i_wr_chan`, in, CHAN_BITS: target channel.
- `i_wr_duty`, in, PWM_BITS+1: new duty value. Values ≥2^N are treated as 2^N.
- `o_pwm`, out, CHANNELS: registered PWM outputs.
- `o_counter`, out, PWM_BITS: current period counter.
- `o_period_start`, out, 1: one-cycle pulse when the counter loads 0 on a tick.

## Operation
Reset values:
- counter = 0, direction = up, prescale count = 0.
- All shadow and active duty registers = 0.
- o_pwm = 0, o_period_start = 0.

Prescaler:
- The prescale count increments each clock while i_enable = 1.
- A tick fires when count ≥ i_prescale; the count then returns to 0.
- i_prescale = 0 gives a tick on every clock.
- A change to i_prescale takes effect immediately. The ≥ compare prevents a runaway count.

Counter (sawtooth, default):
- Steps 0 → 2^N−1 on ticks, then wraps to 0.
- Period = 2^N ticks.

Duty buffering:
- A write sets shadow[i_wr_chan] = min(i_wr_duty, 2^N).
- i_wr_chan ≥ CHANNELS: the write is ignored.
- Boundary = a tick on which the counter becomes 0. At every boundary, active[c] ← shadow[c] for all channels.
- A write in the same cycle as a boundary: the written value is loaded straight into active for that channel (write-through).

Compare and enable:
- o_pwm[c] = (counter < active[c]). o_pwm is registered from the next-state counter and next-state active, so o_pwm and o_counter are always coherent.
- Duty 0 gives a constant low output; duty 2^N gives a constant high output.
- i_enable = 0: the counter, direction and prescale count hold. o_pwm is forced to 0 on the next edge and o_period_start stays 0. Shadow writes are still accepted.
- On re-enable, counting resumes from the held counter value.

## Timing
- Write-to-effect latency: the first boundary after the write, up to one full period.
- o_period_start is high for exactly the one clock in which o_counter first shows 0 after a boundary tick.
- After reset with i_enable = 1 and i_prescale = 0:
  - o_counter = 1 after the first edge.
  - The first boundary occurs at edge 2^N.
- Reset asserted mid-period: all state clears immediately (asynchronous). o_pwm drops without waiting for the period to end.

## Configuration
- `PWM_CENTER_ALIGN_EN` defined: the counter runs as a triangle, 0 → 2^N−1 and then down to 1, giving a period of 2^(N+1)−2 ticks.
  - The direction reverses at 2^N−1 and at 0.
  - The boundary is the valley (counter becomes 0), and o_period_start pulses there.
  - Outputs are symmetric about the peak.
- `PWM_CENTER_ALIGN_EN` undefined: sawtooth only; no direction register is instantiated.
- Ports are identical in both builds.

## Test plan
- Reset, N=8, prescale 0, write ch0 duty 64 → active takes 64 at the first boundary. ch0 is high for 64 clocks out of each 256-clock period, and o_period_start pulses every 256 clocks.
- Write duty 0 to ch1 and 256 to ch2 → ch1 is constantly low and ch2 constantly high across two periods. Write duty 300 → behaves as 256.
- i_prescale = 3 → o_counter advances every 4 clocks and the period is 1024 clocks. Changing to 1 while the count is 3 → a tick on the next clock, then every 2 clocks.
- Write ch3 duty 10 in the exact boundary cycle → ch3 is high for counters 0..9 in that same period. A write with i_wr_chan = 7 (CHANNELS = 4) → no channel changes.
- Drop i_enable at counter 100 for 50 clocks → o_pwm = 0 and the counter holds at 100; on re-enable it resumes at 101. Assert i_reset mid-period → all outputs are 0 at once.
- With PWM_CENTER_ALIGN_EN, N=4, duty 4 → period of 30 clocks. Output is high for counter values 0..3 on both slopes, and o_period_start pulses only at the valley.
